// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-side bus responder:
// FSM states, instruction masks, DDRAM line geometry and AC helpers.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    EXEC  = 2'd2
  } lcd_state_e;

  localparam logic [7:0] INS_CLR   = 8'h01;
  localparam logic [7:0] INS_HOME  = 8'h02;
  localparam logic [7:0] INS_ENTRY = 8'h04;
  localparam logic [7:0] INS_DISP  = 8'h08;
  localparam logic [7:0] INS_SHIFT = 8'h10;
  localparam logic [7:0] INS_FUNC  = 8'h20;
  localparam logic [7:0] INS_CGRAM = 8'h40;
  localparam logic [7:0] INS_DDRAM = 8'h80;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_END  = 7'h27;
  localparam logic [6:0] LINE2_END  = 7'h67;

  localparam logic [7:0] FILL_CHAR = 8'h20;

  // Next AC value; the two display lines form one ring 0x00..0x27, 0x40..0x67.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == LINE1_END) begin
        nxt = LINE2_BASE;
      end else if (ac == LINE2_END) begin
        nxt = LINE1_BASE;
      end else begin
        nxt = ac + 7'd1;
      end
    end else begin
      if (ac == LINE1_BASE) begin
        nxt = LINE2_END;
      end else if (ac == LINE2_BASE) begin
        nxt = LINE1_END;
      end else begin
        nxt = ac - 7'd1;
      end
    end
    return nxt;
  endfunction

  // {valid, index}: only the first 16 columns of each line are mirrored.
  function automatic logic [5:0] ac_to_index(input logic [6:0] ac);
    logic valid;
    valid = (ac[6:4] == 3'b000) || (ac[6:4] == 3'b100);
    return {valid, ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_ddram_shadow.sv
// 32-entry DDRAM mirror: one write port, a registered host read port and a
// combinational bus read port; reset fills every entry with a space.
module lcd_ddram_shadow
  import lcd_pkg::*;
#(
  parameter int SIZE_DATA = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [4:0]           wr_idx_i,
  input  logic [SIZE_DATA-1:0] wr_data_i,
  input  logic [4:0]           host_addr_i,
  output logic [SIZE_DATA-1:0] host_data_o,
  input  logic [4:0]           bus_addr_i,
  output logic [SIZE_DATA-1:0] bus_data_o
);

  logic [SIZE_DATA-1:0] mem_q [32];
  logic [SIZE_DATA-1:0] host_data_q;

  // Storage and host read register; the host sees the pre-write value on a collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= SIZE_DATA'(FILL_CHAR);
      end
      host_data_q <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_idx_i] <= wr_data_i;
      end
      host_data_q <= mem_q[host_addr_i];
    end
  end

  assign host_data_o = host_data_q;
  assign bus_data_o  = mem_q[bus_addr_i];

endmodule

// File: rtl/lcd_bus_responder.sv
// LCD-side responder of the HD44780 parallel bus: synchronizes the bus,
// decodes writes on the E falling edge, tracks AC/busy and mirrors DDRAM.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int SIZE_DATA = 8,
  parameter int FREQ      = 50_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_LCD_E,
  input  logic                 i_LCD_RS,
  input  logic                 i_LCD_RW,
  input  logic [SIZE_DATA-1:0] i_LCD_DATA,
  output logic [SIZE_DATA-1:0] o_LCD_DATA,
  output logic                 o_LCD_DATA_oe,
  input  logic [4:0]           i_rd_addr,
  output logic [SIZE_DATA-1:0] o_rd_char,
  output logic                 o_busy,
  output logic [6:0]           o_ac,
  output logic                 o_display_on,
  output logic                 o_cmd_valid,
  output logic [SIZE_DATA-1:0] o_cmd,
  output logic                 o_overrun
);

  localparam int CMD_CYC = FREQ / 1_000_000 * 37;
  localparam int CLR_CYC = FREQ / 1_000_000 * 1520;
  localparam int CNT_W   = $clog2(CLR_CYC + 1);

  logic e_meta_q, e_sync_q, e_prev_q;
  logic rs_meta_q, rs_sync_q, rw_meta_q, rw_sync_q;
  logic [SIZE_DATA-1:0] data_meta_q, data_sync_q;

  lcd_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4:0]           fill_q, fill_d;
  logic [6:0]           ac_q, ac_d;
  logic                 id_q, id_d;
  logic                 disp_q, disp_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [SIZE_DATA-1:0] cmd_q, cmd_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q;

  logic                 strobe_s, busy_s, wr_strobe_s, rd_strobe_s;
  logic [7:0]           ins_s;
  logic [5:0]           ac_map_s;
  logic                 wr_en_s;
  logic [4:0]           wr_idx_s;
  logic [SIZE_DATA-1:0] wr_data_s;
  logic [SIZE_DATA-1:0] bus_char_s;

  // Two-flop synchronizers on all bus inputs, plus E history for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      e_meta_q    <= 1'b0;
      e_sync_q    <= 1'b0;
      e_prev_q    <= 1'b0;
      rs_meta_q   <= 1'b0;
      rs_sync_q   <= 1'b0;
      rw_meta_q   <= 1'b0;
      rw_sync_q   <= 1'b0;
      data_meta_q <= '0;
      data_sync_q <= '0;
    end else begin
      e_meta_q    <= i_LCD_E;
      e_sync_q    <= e_meta_q;
      e_prev_q    <= e_sync_q;
      rs_meta_q   <= i_LCD_RS;
      rs_sync_q   <= rs_meta_q;
      rw_meta_q   <= i_LCD_RW;
      rw_sync_q   <= rw_meta_q;
      data_meta_q <= i_LCD_DATA;
      data_sync_q <= data_meta_q;
    end
  end

  assign strobe_s    = e_prev_q & ~e_sync_q;
  assign busy_s      = (state_q != IDLE);
  assign wr_strobe_s = strobe_s & ~rw_sync_q;
  assign rd_strobe_s = strobe_s & rw_sync_q & rs_sync_q;
  assign ins_s       = data_sync_q[7:0];
  assign ac_map_s    = ac_to_index(ac_q);

  // Next-state logic: clear/busy sequencing first, then the bus strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    ac_d        = ac_q;
    id_d        = id_q;
    disp_d      = disp_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    overrun_d   = 1'b0;
    wr_en_s     = 1'b0;
    wr_idx_s    = fill_q;
    wr_data_s   = SIZE_DATA'(FILL_CHAR);

    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
      end
      CLEAR: begin
        wr_en_s = 1'b1;
        fill_d  = fill_q + 5'd1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (fill_q == 5'd31) begin
          state_d = EXEC;
        end else begin
          state_d = CLEAR;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Writes are only accepted from IDLE, so they never collide with the clear fill.
    if (wr_strobe_s) begin
      if (busy_s) begin
        overrun_d = 1'b1;
      end else if (rs_sync_q) begin
        wr_en_s   = ac_map_s[5];
        wr_idx_s  = ac_map_s[4:0];
        wr_data_s = data_sync_q;
        ac_d      = ac_step(ac_q, id_q);
        state_d   = EXEC;
        cnt_d     = CNT_W'(CMD_CYC - 1);
      end else if (ins_s != 8'h00) begin
        cmd_valid_d = 1'b1;
        cmd_d       = data_sync_q;
        state_d     = EXEC;
        cnt_d       = CNT_W'(CMD_CYC - 1);
        if ((ins_s & INS_DDRAM) != 8'h00) begin
          ac_d = ins_s[6:0];
        end else if ((ins_s & (INS_CGRAM | INS_FUNC | INS_SHIFT)) != 8'h00) begin
          ac_d = ac_q;
        end else if ((ins_s & INS_DISP) != 8'h00) begin
          disp_d = ins_s[2];
        end else if ((ins_s & INS_ENTRY) != 8'h00) begin
          id_d = ins_s[1];
        end else if ((ins_s & INS_HOME) != 8'h00) begin
          ac_d  = LINE1_BASE;
          cnt_d = CNT_W'(CLR_CYC - 1);
        end else begin
          ac_d    = LINE1_BASE;
          id_d    = 1'b1;
          fill_d  = 5'd0;
          state_d = CLEAR;
          cnt_d   = CNT_W'(CLR_CYC - 1);
        end
      end else begin
        cmd_valid_d = 1'b0;
      end
    end else if (rd_strobe_s) begin
      ac_d = ac_step(ac_q, id_q);
    end else begin
      ac_d = ac_d;
    end
  end

  // Control state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_q      <= 5'd0;
      ac_q        <= 7'd0;
      id_q        <= 1'b1;
      disp_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      ac_q        <= ac_d;
      id_q        <= id_d;
      disp_q      <= disp_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      overrun_q   <= overrun_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  lcd_ddram_shadow #(
    .SIZE_DATA(SIZE_DATA)
  ) u_shadow (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .wr_en_i    (wr_en_s),
    .wr_idx_i   (wr_idx_s),
    .wr_data_i  (wr_data_s),
    .host_addr_i(i_rd_addr),
    .host_data_o(o_rd_char),
    .bus_addr_i (ac_map_s[4:0]),
    .bus_data_o (bus_char_s)
  );

  // Read-back bus: driven only while the synchronized E and RW are both high.
  always_comb begin
    o_LCD_DATA_oe = e_sync_q & rw_sync_q;
    o_LCD_DATA    = '0;
    if (o_LCD_DATA_oe) begin
      if (rs_sync_q) begin
        o_LCD_DATA = ac_map_s[5] ? bus_char_s : SIZE_DATA'(FILL_CHAR);
      end else begin
        o_LCD_DATA = SIZE_DATA'({busy_q, ac_q});
      end
    end else begin
      o_LCD_DATA = '0;
    end
  end

  assign o_busy       = busy_q;
  assign o_ac         = ac_q;
  assign o_display_on = disp_q;
  assign o_cmd_valid  = cmd_valid_q;
  assign o_cmd        = cmd_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: vector table, directed corner
// sequences and a randomized phase against a behavioural display model.
module tb_lcd_bus_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_din = 8'h00;
  logic [7:0] lcd_dout;
  logic       lcd_oe;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic       busy;
  logic [6:0] ac;
  logic       disp_on;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  lcd_bus_responder #(.SIZE_DATA(8), .FREQ(1_000_000)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_LCD_E(lcd_e), .i_LCD_RS(lcd_rs), .i_LCD_RW(lcd_rw), .i_LCD_DATA(lcd_din),
    .o_LCD_DATA(lcd_dout), .o_LCD_DATA_oe(lcd_oe),
    .i_rd_addr(rd_addr), .o_rd_char(rd_char),
    .o_busy(busy), .o_ac(ac), .o_display_on(disp_on),
    .o_cmd_valid(cmd_valid), .o_cmd(cmd), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters and busy-run length observed on the falling edge.
  int cmd_cnt = 0, ovr_cnt = 0, busy_run = 0, last_busy_len = 0;
  logic [7:0] last_cmd = 8'h00;
  always @(negedge clk) begin
    if (cmd_valid) begin
      cmd_cnt++;
      last_cmd = cmd;
    end
    if (overrun) ovr_cnt++;
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  // Behavioural model of the display state.
  logic [7:0] m_mem [32];
  int         m_ac;
  logic       m_id, m_disp;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_ac = 0; m_id = 1'b1; m_disp = 1'b0;
  endtask

  function automatic int m_index(input int a);
    if (a < 16) return a;
    if (a >= 'h40 && a < 'h50) return a - 'h40 + 16;
    return -1;
  endfunction

  function automatic int m_next(input int a, input logic inc);
    if (inc) return (a == 'h27) ? 'h40 : (a == 'h67) ? 0 : (a + 1) % 128;
    return (a == 0) ? 'h67 : (a == 'h40) ? 'h27 : (a + 127) % 128;
  endfunction

  task automatic model_write(input logic rs, input logic [7:0] d);
    int idx;
    if (rs) begin
      idx = m_index(m_ac);
      if (idx >= 0) m_mem[idx] = d;
      m_ac = m_next(m_ac, m_id);
    end else if (d >= 8'h80) m_ac = d - 8'h80;
    else if (d >= 8'h10) m_ac = m_ac;
    else if (d >= 8'h08) m_disp = d[2];
    else if (d >= 8'h04) m_id = d[1];
    else if (d >= 8'h02) m_ac = 0;
    else if (d == 8'h01) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_ac = 0; m_id = 1'b1;
    end
  endtask

  function automatic logic [7:0] m_char();
    int idx;
    idx = m_index(m_ac);
    return (idx >= 0) ? m_mem[idx] : 8'h20;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_din = d; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] v, output logic oe);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    v = lcd_dout; oe = lcd_oe;
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d);
    bus_write(rs, d);
    model_write(rs, d);
    wait_idle();
  endtask

  task automatic read_entry(input int i, output logic [7:0] v);
    @(negedge clk);
    rd_addr = i[4:0];
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic cmp_all(input string name);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      read_entry(i, v);
      chk($sformatf("%s[%0d]", name, i), {24'd0, v}, {24'd0, m_mem[i]});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [6:0] exp_ac;
  } vec_t;
  vec_t tbl[13];

  initial begin
    logic [7:0] v;
    logic       oe;
    int         c0, o0, op, a;

    tbl[0]  = '{1'b0, 8'h06, 7'h00};
    tbl[1]  = '{1'b0, 8'h80, 7'h00};
    tbl[2]  = '{1'b1, 8'h48, 7'h01};
    tbl[3]  = '{1'b1, 8'h69, 7'h02};
    tbl[4]  = '{1'b0, 8'hC0, 7'h40};
    tbl[5]  = '{1'b1, 8'h57, 7'h41};
    tbl[6]  = '{1'b0, 8'hA7, 7'h27};
    tbl[7]  = '{1'b1, 8'h41, 7'h40};
    tbl[8]  = '{1'b0, 8'hE7, 7'h67};
    tbl[9]  = '{1'b1, 8'h33, 7'h00};
    tbl[10] = '{1'b0, 8'h04, 7'h00};
    tbl[11] = '{1'b0, 8'hC0, 7'h40};
    tbl[12] = '{1'b1, 8'h42, 7'h27};

    do_reset();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ac", {25'd0, ac}, 32'd0);
    chk("rst_disp", {31'd0, disp_on}, 32'd0);
    chk("rst_oe", {31'd0, lcd_oe}, 32'd0);
    chk("rst_cmd", {24'd0, cmd}, 32'd0);
    cmp_all("rst_mem");

    // Display on, then a second write while still busy.
    c0 = cmd_cnt; o0 = ovr_cnt;
    bus_write(1'b0, 8'h0C);
    model_write(1'b0, 8'h0C);
    chk("dispon_pulse", cmd_cnt - c0, 1);
    chk("dispon_cmd", {24'd0, cmd}, 32'h0C);
    chk("dispon_disp", {31'd0, disp_on}, 32'd1);
    chk("dispon_busy", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    bus_write(1'b0, 8'h08);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    chk("ovr_nocmd", cmd_cnt - c0, 1);
    chk("ovr_cmd", {24'd0, cmd}, 32'h0C);
    chk("ovr_disp", {31'd0, disp_on}, 32'd1);
    wait_idle();
    chk("cmd_busy_len", last_busy_len, 37);

    // Vector table: AC after each write, including both wrap directions.
    for (int i = 0; i < 13; i++) begin
      do_write(tbl[i].rs, tbl[i].d);
      chk($sformatf("tbl_ac[%0d]", i), {25'd0, ac}, {25'd0, tbl[i].exp_ac});
    end
    read_entry(0, v);  chk("tbl_e0", {24'd0, v}, 32'h48);
    read_entry(1, v);  chk("tbl_e1", {24'd0, v}, 32'h69);
    read_entry(16, v); chk("tbl_e16", {24'd0, v}, 32'h42);
    cmp_all("tbl_mem");

    // Randomized operations against the model.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 1) begin
        a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127)
                                         : ($urandom_range(0, 1) * 'h40 + $urandom_range(0, 15));
        do_write(1'b0, 8'h80 | a[7:0]);
      end else if (op == 2) begin
        v = $urandom_range(0, 1) ? (8'h04 | 8'($urandom_range(0, 3)))
                                 : (8'h08 | 8'($urandom_range(0, 7)));
        do_write(1'b0, v);
        chk("rnd_disp", {31'd0, disp_on}, {31'd0, m_disp});
      end else if (op <= 7) begin
        do_write(1'b1, 8'($urandom_range(0, 255)));
      end else if (op == 8) begin
        bus_read(1'b1, v, oe);
        chk("rnd_rd_oe", {31'd0, oe}, 32'd1);
        chk("rnd_rd_data", {24'd0, v}, {24'd0, m_char()});
        m_ac = m_next(m_ac, m_id);
      end else begin
        do_write(1'b0, 8'h02);
      end
      chk("rnd_ac", {25'd0, ac}, m_ac);
    end
    cmp_all("rnd_mem");

    // Status read while busy: no side effect on AC.
    bus_write(1'b0, 8'h85);
    model_write(1'b0, 8'h85);
    bus_read(1'b0, v, oe);
    chk("stat_oe", {31'd0, oe}, 32'd1);
    chk("stat_data", {24'd0, v}, 32'h85);
    chk("stat_oe_off", {31'd0, lcd_oe}, 32'd0);
    chk("stat_ac", {25'd0, ac}, 32'h05);
    wait_idle();

    // Data read-back advances AC.
    do_write(1'b0, 8'h06);
    do_write(1'b0, 8'h80);
    do_write(1'b1, 8'h30);
    do_write(1'b0, 8'h80);
    bus_read(1'b1, v, oe);
    chk("rd_oe", {31'd0, oe}, 32'd1);
    chk("rd_data", {24'd0, v}, 32'h30);
    chk("rd_ac", {25'd0, ac}, 32'h01);
    chk("rd_busy", {31'd0, busy}, 32'd0);
    m_ac = m_next(m_ac, m_id);

    // Clear: fills within 32 cycles, busy 1520, AC=0, ID back to increment.
    do_write(1'b0, 8'h04);
    c0 = cmd_cnt;
    bus_write(1'b0, 8'h01);
    model_write(1'b0, 8'h01);
    chk("clr_pulse", cmd_cnt - c0, 1);
    chk("clr_ac", {25'd0, ac}, 32'd0);
    repeat (33) @(negedge clk);
    cmp_all("clr_mem");
    chk("clr_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    chk("clr_busy_len", last_busy_len, 1520);
    do_write(1'b1, 8'h5A);
    chk("clr_id_inc", {25'd0, ac}, 32'h01);

    // Async reset in the middle of a clear.
    do_write(1'b0, 8'h0C);
    do_write(1'b0, 8'hCA);
    do_write(1'b1, 8'h77);
    bus_write(1'b0, 8'h01);
    repeat (10) @(negedge clk);
    do_reset();
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_ac", {25'd0, ac}, 32'd0);
    chk("mid_disp", {31'd0, disp_on}, 32'd0);
    cmp_all("mid_mem");
    repeat (40) @(negedge clk);
    chk("mid_busy_late", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
